// File: rtl/prewish_mask_sender.sv
// Mask-load initiator: paces strobed 8-bit writes from a 4-entry rotating table with ACK timeout.
// Optional feature: define PREWISH_SENDER_RETRY_EN to re-strobe once after the first timeout.
module prewish_mask_sender #(
    parameter int unsigned NEWMASK_CLK_BITS = 26,
    parameter int unsigned ACK_TIMEOUT      = 15
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    output logic       o_stb,
    output logic [7:0] o_dat,
    input  logic       i_ack,
    input  logic       i_tbl_we,
    input  logic [1:0] i_tbl_addr,
    input  logic [7:0] i_tbl_data,
    output logic       o_err,
    output logic       o_overrun
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        ABORT
`ifdef PREWISH_SENDER_RETRY_EN
        , RETRY
`endif
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t                        state;
    logic [NEWMASK_CLK_BITS-1:0]   ivl_cnt;
    logic                          tick;
    logic [1:0]                    idx;
    logic [7:0]                    tcnt;
    logic [7:0]                    tbl [4];
`ifdef PREWISH_SENDER_RETRY_EN
    logic                          retried;
`endif

    assign tick = &ivl_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ivl_cnt <= '0;
        end else begin
            ivl_cnt <= ivl_cnt + 1'b1;
        end
    end

    // A write to the entry being latched this edge lands after the latch reads the old value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tbl[0] <= 8'b1010_1000;
            tbl[1] <= 8'b1100_1010;
            tbl[2] <= 8'b1111_0000;
            tbl[3] <= 8'b1000_0000;
        end else if (i_tbl_we) begin
            tbl[i_tbl_addr] <= i_tbl_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            o_stb     <= 1'b0;
            o_dat     <= '0;
            o_err     <= 1'b0;
            o_overrun <= 1'b0;
            idx       <= '0;
            tcnt      <= '0;
`ifdef PREWISH_SENDER_RETRY_EN
            retried   <= 1'b0;
`endif
        end else begin
            o_err <= 1'b0;
            if (tick && state != IDLE) begin
                o_overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tick) begin
                        o_dat <= tbl[idx];
                        o_stb <= 1'b1;
                        tcnt  <= '0;
`ifdef PREWISH_SENDER_RETRY_EN
                        retried <= 1'b0;
`endif
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (i_ack) begin
                        o_stb <= 1'b0;
                        idx   <= idx + 2'd1;
                        state <= IDLE;
                    end else if (tcnt == TO_LAST) begin
                        o_stb <= 1'b0;
`ifdef PREWISH_SENDER_RETRY_EN
                        if (!retried) begin
                            retried <= 1'b1;
                            state   <= RETRY;
                        end else begin
                            o_err <= 1'b1;
                            state <= ABORT;
                        end
`else
                        o_err <= 1'b1;
                        state <= ABORT;
`endif
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                ABORT: begin
                    idx   <= idx + 2'd1;
                    state <= IDLE;
                end
`ifdef PREWISH_SENDER_RETRY_EN
                // Gap cycle, then re-strobe the same latched o_dat with a fresh timeout.
                RETRY: begin
                    o_stb <= 1'b1;
                    tcnt  <= '0;
                    state <= SEND;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prewish_mask_sender.sv
// Bench for prewish_mask_sender: random ACK latencies and table writes against a per-interval waveform model.
// Honours PREWISH_SENDER_RETRY_EN to match the retry build.
module tb_prewish_mask_sender;

    localparam int NB = 4;
    localparam int TO = 3;
    localparam int IV = 1 << NB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ack = 1'b0;
    logic       we = 1'b0;
    logic [1:0] addr = '0;
    logic [7:0] wdata = '0;
    logic       stb;
    logic [7:0] dat;
    logic       err;
    logic       ovr;

    prewish_mask_sender #(
        .NEWMASK_CLK_BITS(NB),
        .ACK_TIMEOUT(TO)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .o_stb(stb),
        .o_dat(dat),
        .i_ack(ack),
        .i_tbl_we(we),
        .i_tbl_addr(addr),
        .i_tbl_data(wdata),
        .o_err(err),
        .o_overrun(ovr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int phase = 0;
    int mode = 5;   // 0..2: ACK latency, 3: ACK only after strobe ends, 4: no ACK, 5: ACK tied high
    logic [7:0] mtbl [4];
    int midx;
    logic [7:0] d_cur;
    bit pend;
    logic [1:0] pend_a;
    logic [7:0] pend_d;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        mtbl[0] = 8'hA8; mtbl[1] = 8'hCA; mtbl[2] = 8'hF0; mtbl[3] = 8'h80;
        midx = 0;
        pend = 0;
    endtask

    function automatic int pick_mode(input int k);
        if (phase == 1) return 4;
        if (k <= 5) return 5;
        if (k == 6) return 4;
        if (k == 7) return 2;
        if (k == 8) return 0;
        if (k == 9) return 1;
        if (k == 10) return 3;
        return int'($urandom_range(0, 4));
    endfunction

    task automatic run(input int n_int, input int rnd_from);
        int k, r;
        bit es, ee;
        for (int c = 1; c < IV * (n_int + 1); c++) begin
            @(negedge clk);
            cyc = c;
            k = c / IV;
            r = c % IV;
            if (r == 0) begin
                d_cur = mtbl[midx];
                midx = (midx + 1) % 4;
                if (pend) begin
                    mtbl[pend_a] = pend_d;
                    pend = 0;
                end
                mode = pick_mode(k);
            end
            es = 0;
            ee = 0;
            if (k > 0) begin
                if (mode <= 2) es = (r <= mode);
                else if (mode == 5) es = (r == 0);
                else begin
`ifdef PREWISH_SENDER_RETRY_EN
                    es = (r <= TO - 1) || (r >= TO + 1 && r <= 2 * TO);
                    ee = (r == 2 * TO + 1);
`else
                    es = (r <= TO - 1);
                    ee = (r == TO);
`endif
                end
            end
            chk("stb", {7'd0, stb}, {7'd0, es});
            chk("err", {7'd0, err}, {7'd0, ee});
            chk("overrun", {7'd0, ovr}, 8'd0);
            if (es) chk("dat", dat, d_cur);

            case (mode)
                5: ack = 1'b1;
                4: ack = 1'b0;
                3: ack = (r == TO);
                default: ack = (r == mode);
            endcase
            we = 1'b0;
            if (phase == 0 && k == 6 && r == 1) begin
                we = 1'b1; addr = 2'd1; wdata = 8'h55;
            end else if (k >= rnd_from && $urandom_range(0, 7) == 0) begin
                we = 1'b1; addr = 2'($urandom_range(0, 3)); wdata = 8'($urandom);
            end
            if (we) begin
                if (r == IV - 1) begin
                    pend = 1; pend_a = addr; pend_d = wdata;
                end else begin
                    mtbl[addr] = wdata;
                end
            end
        end
        ack = 1'b0;
        we = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stb", {7'd0, stb}, 8'd0);
        chk("rst_dat", dat, 8'h00);
        chk("rst_err", {7'd0, err}, 8'd0);
        chk("rst_overrun", {7'd0, ovr}, 8'd0);
        ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        phase = 0;
        mode = 5;
        run(40, 11);

        // Next tick raises a strobe with no ACK; reset is pulled mid-strobe.
        @(negedge clk);
        cyc++;
        chk("pre_rst_stb", {7'd0, stb}, 8'd1);
        @(posedge clk);
        #2;
        chk("mid_stb", {7'd0, stb}, 8'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_stb", {7'd0, stb}, 8'd0);
        chk("async_rst_err", {7'd0, err}, 8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        phase = 1;
        mode = 4;
        run(1, 1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
